// File: rtl/ysyx_23060124_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// funct3 access-size codes and AXI response codes.
package ysyx_23060124_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_D = 3'd2,
    S_WR   = 3'd3,
    S_WR_B = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  // Load sizes (bit 2 = zero-extend)
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store sizes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bit offset of byte lane `off` within a word.
  function automatic logic [4:0] lane_bits(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_23060124_lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
//   funct3_i   : access size/sign
//   off_i      : low address bits selecting the byte lane
//   rdata_i    : raw bus word for loads  -> ld_data_o (extended)
//   wdata_i    : store data (LSB aligned) -> st_data_o (lane shifted), st_strb_o
module ysyx_23060124_lsu_align
  import ysyx_23060124_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    funct3_i,
  input  logic [1:0]    off_i,
  input  logic [DW-1:0] rdata_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] ld_data_o,
  output logic [DW-1:0] st_data_o,
  output logic [3:0]    st_strb_o
);

  logic [DW-1:0] lane;
  assign lane = rdata_i >> lane_bits(off_i);

  always_comb begin
    ld_data_o = rdata_i;
    case (funct3_i)
      LB:      ld_data_o = {{(DW-8){lane[7]}}, lane[7:0]};
      LH:      ld_data_o = {{(DW-16){lane[15]}}, lane[15:0]};
      LBU:     ld_data_o = {{(DW-8){1'b0}}, lane[7:0]};
      LHU:     ld_data_o = {{(DW-16){1'b0}}, lane[15:0]};
      LW:      ld_data_o = rdata_i;
      default: ld_data_o = rdata_i;
    endcase
  end

  assign st_data_o = wdata_i << lane_bits(off_i);

  always_comb begin
    st_strb_o = 4'b1111;
    case (funct3_i)
      SB:      st_strb_o = 4'b0001 << off_i;
      SH:      st_strb_o = 4'b0011 << off_i;
      SW:      st_strb_o = 4'b1111;
      default: st_strb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ysyx_23060124_lsu.sv
// Load/store stage between execute and write-back.
// Accepts one instruction (i_pre_valid/o_pre_ready), performs a single-beat
// AXI4-Lite read or write for loads/stores, and presents the result on
// o_res with o_post_valid/i_post_ready. Non-memory ops pass i_addr through.
// Ports: clock/reset (sync, active high); execute side i_pre_*, i_ren,
// i_wen_mem, i_funct3, i_addr, i_wdata; write-back side o_post_valid,
// i_post_ready, o_res; AXI AR/R/AW/W/B channels.
// Optional: LSU_ACCESS_FAULT_EN adds o_acc_fault (nonzero rresp/bresp).
module ysyx_23060124_lsu
  import ysyx_23060124_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_pre_valid,
  output logic          o_pre_ready,
  input  logic          i_ren,
  input  logic          i_wen_mem,
  input  logic [2:0]    i_funct3,
  input  logic [DW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_post_valid,
  input  logic          i_post_ready,
  output logic [DW-1:0] o_res,
  output logic          o_arvalid,
  input  logic          i_arready,
  output logic [DW-1:0] o_araddr,
  input  logic          i_rvalid,
  output logic          o_rready,
  input  logic [DW-1:0] i_rdata,
  input  logic [1:0]    i_rresp,
  output logic          o_awvalid,
  input  logic          i_awready,
  output logic [DW-1:0] o_awaddr,
  output logic          o_wvalid,
  input  logic          i_wready,
  output logic [DW-1:0] o_wdata,
  output logic [3:0]    o_wstrb,
  input  logic          i_bvalid,
  output logic          o_bready,
  input  logic [1:0]    i_bresp
`ifdef LSU_ACCESS_FAULT_EN
  ,
  output logic          o_acc_fault
`endif
);

  lsu_state_e    state_q, state_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [DW-1:0] res_q, res_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [DW-1:0] ld_data, st_data;
  logic [3:0]    st_strb;

`ifdef LSU_ACCESS_FAULT_EN
  logic fault_q, fault_d;
  assign o_acc_fault = fault_q;
`else
  logic unused_resp;
  assign unused_resp = ^{i_rresp, i_bresp};
`endif

  ysyx_23060124_lsu_align #(.DW(DW)) u_align (
    .funct3_i  (funct3_q),
    .off_i     (addr_q[1:0]),
    .rdata_i   (i_rdata),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data),
    .st_strb_o (st_strb)
  );

  // All handshake outputs decode from registered state only.
  assign o_pre_ready  = (state_q == S_IDLE);
  assign o_arvalid    = (state_q == S_RD_A);
  assign o_rready     = (state_q == S_RD_D);
  assign o_awvalid    = (state_q == S_WR) && !aw_done_q;
  assign o_wvalid     = (state_q == S_WR) && !w_done_q;
  assign o_bready     = (state_q == S_WR_B);
  assign o_post_valid = (state_q == S_DONE);
  assign o_res        = res_q;
  assign o_araddr     = {addr_q[DW-1:2], 2'b00};
  assign o_awaddr     = {addr_q[DW-1:2], 2'b00};
  assign o_wdata      = (state_q == S_WR) ? st_data : '0;
  assign o_wstrb      = (state_q == S_WR) ? st_strb : 4'b0000;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    res_d     = res_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef LSU_ACCESS_FAULT_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_pre_valid) begin
          addr_d    = i_addr;
          wdata_d   = i_wdata;
          funct3_d  = i_funct3;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (i_ren)          state_d = S_RD_A;
          else if (i_wen_mem) state_d = S_WR;
          else begin
            res_d   = i_addr;
            state_d = S_DONE;
          end
        end
      end
      S_RD_A: if (i_arready) state_d = S_RD_D;
      S_RD_D: begin
        if (i_rvalid) begin
          res_d   = ld_data;
          state_d = S_DONE;
`ifdef LSU_ACCESS_FAULT_EN
          fault_d = (i_rresp != RESP_OKAY);
          if (i_rresp != RESP_OKAY) res_d = '0;
`endif
        end
      end
      S_WR: begin
        // Each channel retires independently; leave once both have.
        aw_done_d = aw_done_q | i_awready;
        w_done_d  = w_done_q | i_wready;
        if (aw_done_d && w_done_d) state_d = S_WR_B;
      end
      S_WR_B: begin
        if (i_bvalid) begin
          res_d   = addr_q;
          state_d = S_DONE;
`ifdef LSU_ACCESS_FAULT_EN
          fault_d = (i_bresp != RESP_OKAY);
`endif
        end
      end
      S_DONE: begin
        if (i_post_ready) begin
          state_d = S_IDLE;
`ifdef LSU_ACCESS_FAULT_EN
          fault_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      res_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef LSU_ACCESS_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      res_q     <= res_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef LSU_ACCESS_FAULT_EN
      fault_q   <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_lsu.sv
module tb_ysyx_23060124_lsu;
  import ysyx_23060124_lsu_pkg::*;

  logic        clock = 1'b0, reset = 1'b1;
  logic        i_pre_valid = 0, i_ren = 0, i_wen_mem = 0;
  logic [2:0]  i_funct3 = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, i_rdata = 0;
  logic        i_post_ready = 0, i_arready = 0, i_rvalid = 0;
  logic        i_awready = 0, i_wready = 0, i_bvalid = 0;
  logic [1:0]  i_rresp = 0, i_bresp = 0;
  logic        o_pre_ready, o_post_valid, o_arvalid, o_rready;
  logic        o_awvalid, o_wvalid, o_bready;
  logic [31:0] o_res, o_araddr, o_awaddr, o_wdata;
  logic [3:0]  o_wstrb;
`ifdef LSU_ACCESS_FAULT_EN
  logic        o_acc_fault;
`endif

  int n_cmp = 0, n_bad = 0;

  ysyx_23060124_lsu #(.DW(32)) dut (
    .clock(clock), .reset(reset),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_ren(i_ren), .i_wen_mem(i_wen_mem), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready), .o_res(o_res),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
`ifdef LSU_ACCESS_FAULT_EN
    , .o_acc_fault(o_acc_fault)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * addr[1:0]);
    case (f3)
      3'b000:  return (v % 256 >= 128) ? (v % 256) + 32'hFFFFFF00 : v % 256;
      3'b001:  return (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF0000 : v % 65536;
      3'b100:  return v % 256;
      3'b101:  return v % 65536;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] off);
    int nbytes;
    nbytes = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    return 4'(((1 << nbytes) - 1) << ((nbytes == 4) ? 0 : off));
  endfunction

  function automatic logic [31:0] rand_addr(input logic [2:0] f3);
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if (f3[1:0] == 2'b00)      a = a + $urandom_range(0, 3);
    else if (f3[1:0] == 2'b01) a = a + 2 * $urandom_range(0, 1);
    return a;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic accept(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    i_pre_valid = 1; i_ren = ren; i_wen_mem = wen; i_funct3 = f3;
    i_addr = addr; i_wdata = wd;
    @(negedge clock);
    i_pre_valid = 0; i_ren = 0; i_wen_mem = 0;
  endtask

  task automatic release_done();
    i_post_ready = 1;
    @(negedge clock);
    i_post_ready = 0;
  endtask

  task automatic serve_load(input logic [31:0] rdata, input logic [1:0] resp,
                            input int d1, input int d2,
                            output logic [31:0] araddr, output bit to);
    int n;
    to = 0; n = 0;
    while (!o_arvalid && n < 50) begin @(negedge clock); n++; end
    if (!o_arvalid) begin to = 1; return; end
    repeat (d1) @(negedge clock);
    araddr = o_araddr;
    i_arready = 1; @(negedge clock); i_arready = 0;
    n = 0;
    while (!o_rready && n < 50) begin @(negedge clock); n++; end
    if (!o_rready) begin to = 1; return; end
    repeat (d2) @(negedge clock);
    i_rvalid = 1; i_rdata = rdata; i_rresp = resp;
    @(negedge clock);
    i_rvalid = 0; i_rresp = 0;
  endtask

  // Drives aw/w readies at cycles aw_d/w_d, counting any cycle where a valid
  // does not match "still pending".
  task automatic serve_store(input int aw_d, input int w_d, input int b_d,
                             input logic [1:0] resp, output logic [31:0] awaddr,
                             output logic [31:0] wdata, output logic [3:0] wstrb,
                             output int viol, output bit to);
    int n, last;
    to = 0; viol = 0; n = 0;
    while (!o_awvalid && n < 50) begin @(negedge clock); n++; end
    if (!o_awvalid) begin to = 1; return; end
    awaddr = o_awaddr; wdata = o_wdata; wstrb = o_wstrb;
    last = (aw_d > w_d) ? aw_d : w_d;
    for (int c = 0; c <= last; c++) begin
      if (o_awvalid !== (c <= aw_d) || o_wvalid !== (c <= w_d)) viol++;
      i_awready = (c == aw_d); i_wready = (c == w_d);
      @(negedge clock);
    end
    i_awready = 0; i_wready = 0;
    if (o_awvalid || o_wvalid) viol++;
    n = 0;
    while (!o_bready && n < 50) begin @(negedge clock); n++; end
    if (!o_bready) begin to = 1; return; end
    repeat (b_d) @(negedge clock);
    i_bvalid = 1; i_bresp = resp;
    @(negedge clock);
    i_bvalid = 0; i_bresp = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if ({o_pre_ready, o_post_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready} !== 7'b1000000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 1000000",
        {o_pre_ready, o_post_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready});
    end
    n_cmp++;
    if ({o_res, o_araddr, o_awaddr, o_wdata, o_wstrb} !== '0) begin
      n_bad++; $display("FAIL reset_data res=%h araddr=%h awaddr=%h wdata=%h wstrb=%b want all 0",
        o_res, o_araddr, o_awaddr, o_wdata, o_wstrb);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 32'h1234 : $urandom;
      accept(0, 0, 3'($urandom_range(0, 7)), a, $urandom);
      n_cmp++;
      if (o_post_valid !== 1'b1 || o_res !== a) begin
        n_bad++; $display("FAIL passthrough valid=%b res=%h want 1 %h", o_post_valid, o_res, a);
      end
      n_cmp++;
      if ({o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready} !== 5'b0) begin
        n_bad++; $display("FAIL passthrough_bus got %b want 00000",
          {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready});
      end
      release_done();
    end
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                          input logic [1:0] resp, input string nm);
    logic [31:0] ara, exp;
    bit to;
    accept(1, 0, f3, a, $urandom);
    serve_load(w, resp, $urandom_range(0, 3), $urandom_range(0, 3), ara, to);
    exp = ref_load(f3, a, w);
    n_cmp++;
    if (to !== 1'b0) begin
      n_bad++; $display("FAIL %s timeout got 1 want 0", nm);
      return;
    end
    n_cmp++;
    if (ara !== (a & 32'hFFFF_FFFC)) begin
      n_bad++; $display("FAIL %s araddr got %h want %h", nm, ara, a & 32'hFFFF_FFFC);
    end
    n_cmp++;
    if (o_post_valid !== 1'b1 || o_res !== exp) begin
      n_bad++; $display("FAIL %s f3=%0d a=%h w=%h valid=%b res=%h want %h",
        nm, f3, a, w, o_post_valid, o_res, exp);
    end
    release_done();
  endtask

  task automatic test_load();
    logic [2:0] f3s [5] = '{LB, LH, LW, LBU, LHU};
    logic [2:0] f3;
    run_load(LB, 32'h8000_0003, 32'h80FF_0000, RESP_OKAY, "lb_dir");
    run_load(LBU, 32'h8000_0003, 32'h80FF_0000, RESP_OKAY, "lbu_dir");
    for (int i = 0; i < 15; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      run_load(f3, rand_addr(f3), $urandom, RESP_OKAY, "load_rand");
    end
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int aw_d, input int w_d, input logic [1:0] resp,
                           input string nm);
    logic [31:0] awa, wda, expd;
    logic [3:0]  stb;
    int          viol;
    bit          to;
    logic [31:0] mask;
    accept(0, 1, f3, a, wd);
    serve_store(aw_d, w_d, $urandom_range(0, 3), resp, awa, wda, stb, viol, to);
    n_cmp++;
    if (to !== 1'b0) begin
      n_bad++; $display("FAIL %s timeout got 1 want 0", nm);
      return;
    end
    // only bytes enabled by strobe carry meaning on the bus
    expd = wd * (32'd1 << (8 * a[1:0]));
    mask = 0;
    for (int b = 0; b < 4; b++) if (stb[b]) mask = mask | (32'hFF << (8 * b));
    n_cmp++;
    if (stb !== ref_strb(f3, a[1:0]) || (wda & mask) !== (expd & mask) || awa !== (a & ~32'h3)) begin
      n_bad++; $display("FAIL %s a=%h strb=%b wdata=%h awaddr=%h want %b %h %h",
        nm, a, stb, wda, awa, ref_strb(f3, a[1:0]), expd, a & ~32'h3);
    end
    n_cmp++;
    if (viol !== 0) begin
      n_bad++; $display("FAIL %s valid_drop got %0d bad cycles want 0", nm, viol);
    end
    n_cmp++;
    if (o_post_valid !== 1'b1 || o_res !== a) begin
      n_bad++; $display("FAIL %s done valid=%b res=%h want 1 %h", nm, o_post_valid, o_res, a);
    end
    release_done();
  endtask

  task automatic test_store();
    logic [2:0] f3;
    run_store(SH, 32'h8000_0002, 32'h0000_ABCD, 0, 2, RESP_OKAY, "sh_aw_first");
    n_cmp++;
    if (32'h0000_ABCD * 65536 !== 32'hABCD_0000 || ref_strb(SH, 2'd2) !== 4'b1100) begin
      n_bad++; $display("FAIL sh_model got %b want 1100", ref_strb(SH, 2'd2));
    end
    run_store(SH, 32'h8000_0002, 32'h0000_ABCD, 3, 1, RESP_OKAY, "sh_w_first");
    run_store(SW, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, RESP_OKAY, "sw_same_cycle");
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 2));
      run_store(f3, rand_addr(f3), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                RESP_OKAY, "store_rand");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    a = $urandom;
    accept(0, 0, 3'b000, a, 0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (o_post_valid !== 1'b1 || o_pre_ready !== 1'b0 || o_res !== a) begin
        n_bad++; $display("FAIL backpressure cyc=%0d valid=%b pre_ready=%b res=%h want 1 0 %h",
          i, o_post_valid, o_pre_ready, o_res, a);
      end
      // a second offer while stalled must be ignored
      i_pre_valid = 1; i_addr = ~a;
      @(negedge clock);
    end
    i_pre_valid = 0;
    release_done();
    n_cmp++;
    if (o_pre_ready !== 1'b1 || o_post_valid !== 1'b0) begin
      n_bad++; $display("FAIL backpressure_release pre_ready=%b valid=%b want 1 0",
        o_pre_ready, o_post_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    accept(1, 0, LW, 32'h8000_0040, 0);
    n = 0;
    while (!o_arvalid && n < 20) begin @(negedge clock); n++; end
    i_arready = 1; @(negedge clock); i_arready = 0;
    n_cmp++;
    if (o_rready !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_pre rready got %b want 1", o_rready);
    end
    reset = 1;
    @(negedge clock);
    reset = 0;
    n_cmp++;
    if (o_rready !== 1'b0 || o_post_valid !== 1'b0 || o_pre_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid rready=%b valid=%b pre_ready=%b want 0 0 1",
        o_rready, o_post_valid, o_pre_ready);
    end
    run_load(LH, 32'h8000_0042, 32'h1234_5678, RESP_OKAY, "after_reset");
  endtask

  task automatic test_resp();
`ifdef LSU_ACCESS_FAULT_EN
    logic [31:0] ara;
    bit to;
    accept(1, 0, LW, 32'h8000_0100, 0);
    serve_load(32'hCAFE_F00D, RESP_SLVERR, 1, 1, ara, to);
    n_cmp++;
    if (to !== 1'b0 || o_acc_fault !== 1'b1 || o_res !== 32'h0 || o_post_valid !== 1'b1) begin
      n_bad++; $display("FAIL fault_load to=%b fault=%b res=%h valid=%b want 0 1 0 1",
        to, o_acc_fault, o_res, o_post_valid);
    end
    release_done();
    n_cmp++;
    if (o_acc_fault !== 1'b0) begin
      n_bad++; $display("FAIL fault_clear got %b want 0", o_acc_fault);
    end
    run_store(SW, 32'h8000_0200, 32'h1, 1, 0, RESP_DECERR, "fault_store_pre");
    run_load(LW, 32'h8000_0300, 32'h5555_AAAA, RESP_OKAY, "ok_load");
    n_cmp++;
    if (o_acc_fault !== 1'b0) begin
      n_bad++; $display("FAIL fault_ok got %b want 0", o_acc_fault);
    end
`else
    // response codes carry no meaning without the fault feature
    run_load(LBU, 32'h8000_0101, 32'hCAFE_F00D, RESP_SLVERR, "resp_ignored_load");
    run_store(SB, 32'h8000_0103, 32'h77, 0, 1, RESP_DECERR, "resp_ignored_store");
`endif
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_backpressure();
    test_reset_mid();
    test_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_23060124_lsu.md
Name: ysyx_23060124_lsu

Overview:
Load/store stage sitting directly upstream of the write-back unit. It accepts one instruction at a time from the execute stage over a valid/ready handshake. For loads and stores it performs a single-beat AXI4-Lite-style memory transaction; non-memory instructions pass through. It then presents the result (ALU value or extended load data) to write-back with a registered valid/ready handshake.

Parameters:
DW, 32, data/address width (fixed 32; the parameter exists only for readability)

Ports:
clock  in  1  core clock
reset  in  1  synchronous active-high reset
i_pre_valid  in  1  execute stage holds a valid instruction
o_pre_ready  out  1  LSU can accept (high only in IDLE)
i_ren  in  1  instruction is a load
i_wen_mem  in  1  instruction is a store (i_ren and i_wen_mem are never both high)
i_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_addr  in  32  effective address (ALU result)
i_wdata  in  32  store data (rs2)
o_post_valid  out  1  result valid to write-back
i_post_ready  in  1  write-back accepts
o_res  out  32  load data (extended) or passthrough i_addr
o_arvalid/i_arready  out/in  1  read address handshake; o_araddr out 32
i_rvalid/o_rready  in/out  1  read data handshake; i_rdata in 32; i_rresp in 2
o_awvalid/i_awready  out/in  1  write address; o_awaddr out 32
o_wvalid/i_wready  out/in  1  write data; o_wdata out 32; o_wstrb out 4
i_bvalid/o_bready  in/out  1  write response; i_bresp in 2

Behaviour:
- Reset: state IDLE. All valids, o_rready and o_bready are 0. o_res, addresses, o_wdata and o_wstrb are 0. o_pre_ready = 1 after reset.
- Reset asserted mid-transaction returns the block to IDLE next cycle. Outstanding bus handshakes are abandoned; the memory side is reset by the same signal.
- States: IDLE, RD_A, RD_D, WR, WR_B, DONE.
- IDLE: when i_pre_valid, latch addr, wdata, funct3 and kind.
  - load -> RD_A
  - store -> WR
  - otherwise o_res <= i_addr and go to DONE (one cycle from accept to o_post_valid).
- RD_A: o_arvalid = 1, o_araddr = {addr[31:2], 2'b00}. On i_arready -> RD_D.
- RD_D: o_rready = 1. On i_rvalid, select the lane by addr[1:0] and extend per funct3 (B/H sign, BU/HU zero, W whole word), write o_res, go to DONE.
- WR: o_awvalid and o_wvalid are asserted together. Each drops independently once its own handshake completes (tracked by two done flags). When both are done -> WR_B.
  - o_wdata = data shifted to lane addr[1:0] (by 8*addr[1:0]).
  - o_wstrb: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
  - If both handshakes complete in the same cycle -> WR_B directly.
- WR_B: o_bready = 1. On i_bvalid, o_res <= addr and go to DONE.
- DONE: o_post_valid = 1 and o_res is held stable. On i_post_ready -> IDLE. No new accept in the same cycle, so throughput is at most one instruction every 2 cycles.
- Misaligned H/W accesses are out of scope. The lane is taken from the low address bits only.
- Addresses are word-aligned on the bus. Valids stay high until their handshake; no combinational ready-to-valid paths.

Optional Feature:
LSU_ACCESS_FAULT_EN:
- Defined: adds output o_acc_fault (1 bit). On a nonzero i_rresp or i_bresp it is captured in DONE, valid alongside o_post_valid, and cleared on return to IDLE. For a faulted load, o_res = 0.
- Undefined: the port is absent and resp is ignored.

Decomposition:
- Shared package: state encoding enum, funct3 size constants (LB/LH/LW/LBU/LHU, SB/SH/SW), AXI resp codes OKAY/SLVERR/DECERR.
- One natural sub-module, ysyx_23060124_lsu_align: purely combinational. It does load extraction/extension and store shift plus wstrb generation, and is reused by any future cache path.

Test Plan:
- Non-memory passthrough: i_addr=0x1234 -> o_post_valid one cycle after accept, o_res=0x1234, no bus valid asserted.
- LB at 0x80000003, rdata=0x80FF_0000 -> o_araddr=0x80000000, o_res=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x80000002, wdata=0xABCD -> o_wstrb=4'b1100, o_wdata=0xABCD0000. With aw and w handshakes on different cycles, each valid drops independently.
- Backpressure: i_post_ready low for 5 cycles in DONE -> o_res stable, o_pre_ready=0 throughout.
- Reset pulse while in RD_D -> next cycle IDLE, o_rready=0, o_post_valid=0.
- With LSU_ACCESS_FAULT_EN, a load with rresp=2'b10 -> o_acc_fault=1 and o_res=0 in DONE; it clears after the handshake.
